mem_stage_ctrl: RTL and testbench

- Memory-stage controller that writes the MEM/WB stage register bank.
- Takes the EX/MEM instruction and performs its data-memory access over the dmem request/response interface, including LDI/STI double access and LDB/STB byte lanes.
- Drives the load strobes and contents of the writeback-side stage register, and stalls the upstream pipeline while an access is outstanding.

---
 rtl/lc3b_types.sv | 45 ++++
 rtl/mem_op_decode.sv | 35 +++
 rtl/mem_stage_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b widths, opcode/state enums and small helpers for the pipeline stages.
// Pure type package: no logic, no latency, no flow control.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [7:0]  lc3b_byte;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic {
        IDLE,
        IND2
    } mem_state;

    // MOP_RI: read pointer then read data (LDI); MOP_RW: read pointer then write (STI)
    typedef enum logic [2:0] {
        MOP_NONE,
        MOP_READ,
        MOP_WRITE,
        MOP_RI,
        MOP_RW
    } lc3b_mem_op;

    function automatic lc3b_word sext_byte(input lc3b_byte b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_op_decode.sv
// Opcode -> memory access class and byte-lane flag.
// Purely combinational, zero latency, no flow control.
module mem_op_decode
    import lc3b_types::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] mem_op,
    output logic       is_byte
);

    lc3b_mem_op op;

    always_comb begin
        op      = MOP_NONE;
        is_byte = 1'b0;
        case (lc3b_opcode'(opcode))
            op_ldr, op_trap: op = MOP_READ;
            op_ldb: begin
                op      = MOP_READ;
                is_byte = 1'b1;
            end
            op_str: op = MOP_WRITE;
            op_stb: begin
                op      = MOP_WRITE;
                is_byte = 1'b1;
            end
            op_ldi: op = MOP_RI;
            op_sti: op = MOP_RW;
            default: op = MOP_NONE;
        endcase
    end

    assign mem_op = op;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: performs the EX/MEM data access (incl. LDI/STI double access) and feeds MEM/WB.
// Requests are combinational from decode; stall holds upstream until the final dmem_resp.
module mem_stage_ctrl
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [15:0] ex_ir,
    input  logic [15:0] ex_address,
    input  logic [15:0] ex_data,
    input  logic [3:0]  ex_cs,
    input  logic [15:0] ex_npc,
    input  logic [15:0] ex_aluresult,
    input  logic [2:0]  ex_drid,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic        stall,
    output logic        load_sr,
    output logic [15:0] sr_address_in,
    output logic [15:0] sr_data_in,
    output logic [15:0] sr_npc_in,
    output logic [15:0] sr_aluresult_in,
    output logic [15:0] sr_ir_in,
    output logic [3:0]  sr_cs_in,
    output logic [2:0]  sr_drid_in
);

    mem_state   state;
    mem_state   next_state;
    lc3b_word   ptr;
    logic       ptr_load;
    logic [2:0] dec_op;
    logic       is_byte;
    logic       eff_valid;
    logic       indirect;
    lc3b_mem_op op;
    lc3b_byte   rbyte;

    mem_op_decode u_decode (
        .opcode  (ex_ir[15:12]),
        .mem_op  (dec_op),
        .is_byte (is_byte)
    );

    // Reset is folded in so requests drop the instant rst_n falls, even mid-access.
    assign eff_valid = ex_valid & rst_n;
    assign op        = eff_valid ? lc3b_mem_op'(dec_op) : MOP_NONE;
    assign indirect  = (op == MOP_RI) || (op == MOP_RW);
    assign rbyte     = ex_address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

    always_comb begin
        dmem_address     = {ex_address[15:1], 1'b0};
        dmem_wdata       = ex_data;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = 2'b11;
        stall            = 1'b0;
        ptr_load         = 1'b0;
        next_state       = state;

        if (state == IND2) begin
            dmem_address = {ptr[15:1], 1'b0};
            dmem_read    = (op == MOP_RI);
            dmem_write   = (op == MOP_RW);
            stall        = indirect && !dmem_resp;
            if (!indirect || dmem_resp)
                next_state = IDLE;
        end else begin
            if (is_byte) begin
                dmem_address     = ex_address;
                dmem_byte_enable = ex_address[0] ? 2'b10 : 2'b01;
                if (op == MOP_WRITE)
                    dmem_wdata = {ex_data[7:0], ex_data[7:0]};
            end
            dmem_read  = (op == MOP_READ) || indirect;
            dmem_write = (op == MOP_WRITE);
            if (indirect) begin
                // First access fetches the pointer; the stage register must not load yet.
                stall = 1'b1;
                if (dmem_resp) begin
                    ptr_load   = 1'b1;
                    next_state = IND2;
                end
            end else if (op != MOP_NONE) begin
                stall = !dmem_resp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= next_state;
            if (ptr_load)
                ptr <= dmem_rdata;
        end
    end

    always_comb begin
        sr_data_in = ex_data;
        case (op)
            MOP_READ, MOP_RI: sr_data_in = is_byte ? sext_byte(rbyte) : dmem_rdata;
            default:          sr_data_in = ex_data;
        endcase
    end

    assign load_sr         = !stall;
    assign sr_address_in   = (state == IND2 && indirect) ? ptr : ex_address;
    assign sr_npc_in       = ex_npc;
    assign sr_aluresult_in = ex_aluresult;
    assign sr_drid_in      = ex_drid;
    assign sr_ir_in        = eff_valid ? ex_ir : 16'h0000;
    assign sr_cs_in        = eff_valid ? ex_cs : 4'h0;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [15:0] ex_ir;
    logic [15:0] ex_address;
    logic [15:0] ex_data;
    logic [3:0]  ex_cs;
    logic [15:0] ex_npc;
    logic [15:0] ex_aluresult;
    logic [2:0]  ex_drid;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic        stall;
    logic        load_sr;
    logic [15:0] sr_address_in;
    logic [15:0] sr_data_in;
    logic [15:0] sr_npc_in;
    logic [15:0] sr_aluresult_in;
    logic [15:0] sr_ir_in;
    logic [3:0]  sr_cs_in;
    logic [2:0]  sr_drid_in;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_ir            (ex_ir),
        .ex_address       (ex_address),
        .ex_data          (ex_data),
        .ex_cs            (ex_cs),
        .ex_npc           (ex_npc),
        .ex_aluresult     (ex_aluresult),
        .ex_drid          (ex_drid),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .stall            (stall),
        .load_sr          (load_sr),
        .sr_address_in    (sr_address_in),
        .sr_data_in       (sr_data_in),
        .sr_npc_in        (sr_npc_in),
        .sr_aluresult_in  (sr_aluresult_in),
        .sr_ir_in         (sr_ir_in),
        .sr_cs_in         (sr_cs_in),
        .sr_drid_in       (sr_drid_in)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [15:0] ir, input logic [15:0] addr,
                         input logic [15:0] data, input logic resp, input logic [15:0] rdata);
        ex_valid   = v;
        ex_ir      = ir;
        ex_address = addr;
        ex_data    = data;
        dmem_resp  = resp;
        dmem_rdata = rdata;
    endtask

    // Change inputs just after the rising edge, sample on the falling edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        ex_cs        = 4'h9;
        ex_npc       = 16'h0102;
        ex_aluresult = 16'h0005;
        ex_drid      = 3'd1;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        // Reset state: bubble, no request
        @(negedge clk);
        chk("rst_read", {15'd0, dmem_read}, 16'd0);
        chk("rst_write", {15'd0, dmem_write}, 16'd0);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_load_sr", {15'd0, load_sr}, 16'd1);
        chk("rst_sr_ir", sr_ir_in, 16'h0000);
        chk("rst_sr_cs", {12'd0, sr_cs_in}, 16'd0);
        step();
        rst_n = 1'b1;

        // ADD: non-memory, completes in the same cycle
        drive(1'b1, 16'h1263, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        chk("add_read", {15'd0, dmem_read}, 16'd0);
        chk("add_write", {15'd0, dmem_write}, 16'd0);
        chk("add_stall", {15'd0, stall}, 16'd0);
        chk("add_load_sr", {15'd0, load_sr}, 16'd1);
        chk("add_alu", sr_aluresult_in, 16'h0005);
        chk("add_ir", sr_ir_in, 16'h1263);
        chk("add_cs", {12'd0, sr_cs_in}, 16'h0009);

        // LDR 0x3001: three waiting cycles, then response 0xBEEF
        step();
        drive(1'b1, 16'h6201, 16'h3001, 16'h0000, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ldr_addr", dmem_address, 16'h3000);
            chk("ldr_read", {15'd0, dmem_read}, 16'd1);
            chk("ldr_be", {14'd0, dmem_byte_enable}, 16'h0003);
            chk("ldr_stall", {15'd0, stall}, 16'd1);
            chk("ldr_load_sr", {15'd0, load_sr}, 16'd0);
            step();
        end
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hBEEF;
        @(negedge clk);
        chk("ldr_done_stall", {15'd0, stall}, 16'd0);
        chk("ldr_done_load", {15'd0, load_sr}, 16'd1);
        chk("ldr_data", sr_data_in, 16'hBEEF);

        // LDB 0x4003 back-to-back with an immediate response: high byte 0x80 sign-extended
        step();
        drive(1'b1, 16'h2000, 16'h4003, 16'h0000, 1'b1, 16'h80FF);
        @(negedge clk);
        chk("ldb_read", {15'd0, dmem_read}, 16'd1);
        chk("ldb_addr", dmem_address, 16'h4003);
        chk("ldb_be", {14'd0, dmem_byte_enable}, 16'h0002);
        chk("ldb_data", sr_data_in, 16'hFF80);
        chk("ldb_stall", {15'd0, stall}, 16'd0);

        // STB 0x4002 data 0x1234: low lane, byte replicated
        step();
        drive(1'b1, 16'h3000, 16'h4002, 16'h1234, 1'b0, 16'h0000);
        @(negedge clk);
        chk("stb_write", {15'd0, dmem_write}, 16'd1);
        chk("stb_read", {15'd0, dmem_read}, 16'd0);
        chk("stb_be", {14'd0, dmem_byte_enable}, 16'h0001);
        chk("stb_wdata", dmem_wdata, 16'h3434);
        chk("stb_stall", {15'd0, stall}, 16'd1);
        step();
        dmem_resp = 1'b1;
        @(negedge clk);
        chk("stb_done_load", {15'd0, load_sr}, 16'd1);
        chk("stb_sr_data", sr_data_in, 16'h1234);

        // STI 0x5000: pointer 0x6002, then write 0xA5A5 there
        step();
        drive(1'b1, 16'hB000, 16'h5000, 16'hA5A5, 1'b0, 16'h0000);
        @(negedge clk);
        chk("sti1_read", {15'd0, dmem_read}, 16'd1);
        chk("sti1_addr", dmem_address, 16'h5000);
        chk("sti1_stall", {15'd0, stall}, 16'd1);
        step();
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h6002;
        @(negedge clk);
        chk("sti1_resp_stall", {15'd0, stall}, 16'd1);
        chk("sti1_resp_load", {15'd0, load_sr}, 16'd0);
        step();
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0000;
        @(negedge clk);
        chk("sti2_write", {15'd0, dmem_write}, 16'd1);
        chk("sti2_read", {15'd0, dmem_read}, 16'd0);
        chk("sti2_addr", dmem_address, 16'h6002);
        chk("sti2_wdata", dmem_wdata, 16'hA5A5);
        chk("sti2_be", {14'd0, dmem_byte_enable}, 16'h0003);
        chk("sti2_stall", {15'd0, stall}, 16'd1);
        chk("sti2_load", {15'd0, load_sr}, 16'd0);
        step();
        dmem_resp = 1'b1;
        @(negedge clk);
        chk("sti2_done_stall", {15'd0, stall}, 16'd0);
        chk("sti2_done_load", {15'd0, load_sr}, 16'd1);
        chk("sti2_sr_addr", sr_address_in, 16'h6002);
        chk("sti2_sr_data", sr_data_in, 16'hA5A5);

        // Stray response with nothing outstanding is ignored
        step();
        drive(1'b0, 16'h6000, 16'h1111, 16'h0000, 1'b1, 16'h2222);
        @(negedge clk);
        chk("stray_read", {15'd0, dmem_read}, 16'd0);
        chk("stray_stall", {15'd0, stall}, 16'd0);
        chk("stray_ir", sr_ir_in, 16'h0000);

        // LDI 0x7000 -> pointer 0x8004, then reset while waiting in IND2
        step();
        drive(1'b1, 16'hA000, 16'h7000, 16'h0000, 1'b1, 16'h8004);
        @(negedge clk);
        chk("ldi1_stall", {15'd0, stall}, 16'd1);
        step();
        dmem_resp  = 1'b0;
        dmem_rdata = 16'h0000;
        @(negedge clk);
        chk("ldi2_read", {15'd0, dmem_read}, 16'd1);
        chk("ldi2_addr", dmem_address, 16'h8004);
        chk("ldi2_stall", {15'd0, stall}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ldi_rst_read", {15'd0, dmem_read}, 16'd0);
        chk("ldi_rst_stall", {15'd0, stall}, 16'd0);
        chk("ldi_rst_load", {15'd0, load_sr}, 16'd1);
        step();
        rst_n = 1'b1;
        drive(1'b1, 16'h1263, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        chk("post_add_stall", {15'd0, stall}, 16'd0);
        chk("post_add_load", {15'd0, load_sr}, 16'd1);
        chk("post_add_read", {15'd0, dmem_read}, 16'd0);

        // Fresh LDI must start from IDLE at ex_address, not the stale pointer
        step();
        drive(1'b1, 16'hA000, 16'h7000, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        chk("post_ldi_addr", dmem_address, 16'h7000);
        chk("post_ldi_read", {15'd0, dmem_read}, 16'd1);
        step();
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
